vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single-port 4 KB video RAM between two requesters: VGA scan-out fetch and the CPU bus (vram_cs path).
- Arbitrates every clock, with one access issued per cycle. The VGA requester has priority. A wait counter bounds CPU latency so the CPU cannot be starved.
- Sits between the CPU bus interface / VGA timing generator and the VRAM array. The RAM has synchronous read with 1-cycle latency.

Parameters:
- AW, 12, address width (4096 bytes of VRAM).
- DW, 8, data width.
- MAX_WAIT, 3, number of consecutive cycles a pending CPU request may lose arbitration before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- vga_req  in  1  VGA fetch request (level); sampled every cycle.
- vga_addr  in  AW  VGA fetch address; valid while vga_req is high.
- vga_gnt  out  1  VGA request accepted this cycle (same cycle as issue).
- vga_valid  out  1  one-cycle pulse; vga_rdata is valid.
- vga_rdata  out  DW  VGA read data.
- cpu_stb  in  1  one-cycle CPU access strobe.
- cpu_rw  in  1  1 = read, 0 = write; captured with cpu_stb.
- cpu_addr  in  AW  CPU address; captured with cpu_stb.
- cpu_wdata  in  DW  CPU write data; captured with cpu_stb.
- cpu_busy  out  1  CPU request pending or in flight.
- cpu_done  out  1  one-cycle pulse when the CPU access has completed.
- cpu_rdata  out  DW  last CPU read data; held until the next CPU read completes.
- cpu_overrun  out  1  sticky flag: a cpu_stb arrived while cpu_busy was high. Cleared only by reset.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset values (reset sampled high at a clock edge):
  - All outputs are 0, the pending CPU request is cleared, the wait counter is 0, and cpu_rdata is 0.
  - Any in-flight read is discarded: no vga_valid or cpu_done follows.
- CPU capture:
  - When cpu_stb=1 and cpu_busy=0, latch rw/addr/wdata into the pending register.
  - The pending request becomes eligible for arbitration in the next cycle, and cpu_busy goes to 1 in that same cycle.
  - cpu_stb while cpu_busy=1 is ignored (the latched request is unchanged) and cpu_overrun is set.
- Arbitration, each cycle, combinational on the current inputs and registered state:
  1. If a CPU request is pending and wait_cnt == MAX_WAIT: issue CPU.
  2. Otherwise, if vga_req=1: issue VGA and assert vga_gnt. If a CPU request is pending, wait_cnt increments, saturating at MAX_WAIT.
  3. Otherwise, if a CPU request is pending: issue CPU.
  4. Otherwise: mem_en=0.
  - When CPU is issued, wait_cnt goes to 0.
  - When VGA loses to a forced CPU access, vga_gnt=0. The VGA requester must hold vga_req and vga_addr until it is granted.
- Issue cycle N (mem_* outputs are combinational from the arbitration result):
  - VGA: mem_en=1, mem_we=0, mem_addr=vga_addr.
  - CPU read: mem_en=1, mem_we=0, mem_addr=pending address.
  - CPU write: mem_en=1, mem_we=1, mem_addr and mem_wdata from the pending register.
- Completion at cycle N+1 (registered):
  - VGA read: vga_valid=1, vga_rdata=mem_rdata.
  - CPU read: cpu_done=1, cpu_rdata=mem_rdata (then held).
  - CPU write: cpu_done=1, cpu_rdata unchanged.
  - cpu_busy clears in cycle N+1, when cpu_done is asserted.
  - A new cpu_stb is accepted in cycle N+1 at the earliest (busy-to-strobe turnaround of 0 cycles after done).
- Throughput:
  - Back-to-back VGA grants every cycle are legal. Their vga_valid pulses are likewise back-to-back, delayed by 1 cycle.
  - A CPU request pending under continuous vga_req completes within MAX_WAIT+2 cycles of cpu_busy rising.
- Simultaneous events:
  - cpu_stb in the same cycle as cpu_done: the strobe is accepted (busy is considered clear in that cycle), with no overrun.
  - A CPU write and a VGA read of the same address in consecutive cycles: no forwarding. The VGA read returns the RAM contents as of its issue cycle.
- The wait counter is 4 bits wide and never exceeds MAX_WAIT.

Test Plan:
- Reset, then idle: outputs are all 0. cpu_stb read of 0x123 with RAM[0x123]=0xA5 -> mem_en at N=stb+1, cpu_done and cpu_rdata=0xA5 at N+1, cpu_busy high for exactly 1 cycle.
- vga_req held high with addresses 0x000..0x00F, no CPU -> vga_gnt every cycle; vga_valid pulses 1 cycle later with matching data; no bubbles.
- vga_req held high, CPU write 0x7FF<-0x3C at cycle 10 (MAX_WAIT=3) -> VGA granted for cycles 11–13, CPU issued at 14 with vga_gnt=0, cpu_done at 15; a subsequent CPU read of 0x7FF returns 0x3C.
- Second cpu_stb (write 0x001<-0xFF) while busy -> request ignored, cpu_overrun=1 and stays 1; RAM[0x001] unchanged. Reset clears the flag.
- cpu_stb pulsed in the same cycle as cpu_done -> accepted with no overrun; second access completes normally.
- Reset asserted in the cycle after a VGA issue -> no vga_valid; all outputs are 0 on the next cycle; the pending CPU request is dropped (cpu_done never pulses).

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous-read VRAM between VGA scan-out
// fetch (priority) and a CPU strobe interface with bounded CPU wait.
module vram_arbiter #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_valid,
    output logic [DW-1:0] vga_rdata,
    input  logic          cpu_stb,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_busy,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_overrun,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned WCW = 4;
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    // Pending CPU request; cpu_busy doubles as its valid bit and stays set
    // through the issue cycle.
    logic          pend_rw;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_wdata;
    logic [WCW-1:0] wait_cnt;

    // Completion-side state: a CPU read is landing this cycle, plus held data.
    logic          cpu_rd_q;
    logic [DW-1:0] vga_rdata_q;
    logic [DW-1:0] cpu_rdata_q;

    logic forced;
    logic issue_cpu;
    logic issue_vga;
    logic accept;

    // Arbitration and RAM command for the current cycle.
    always_comb begin
        forced    = 1'b0;
        issue_cpu = 1'b0;
        issue_vga = 1'b0;
        accept    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        vga_gnt   = 1'b0;

        forced    = cpu_busy && (wait_cnt == WAIT_LIMIT);
        issue_vga = vga_req && !forced;
        issue_cpu = cpu_busy && !issue_vga;
        accept    = cpu_stb && !cpu_busy;

        if (issue_vga) begin
            mem_en   = 1'b1;
            mem_addr = vga_addr;
            vga_gnt  = 1'b1;
        end else if (issue_cpu) begin
            mem_en   = 1'b1;
            mem_we   = !pend_rw;
            mem_addr = pend_addr;
            if (!pend_rw) begin
                mem_wdata = pend_wdata;
            end
        end
    end

    // Capture, wait counting and completion registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_busy    <= 1'b0;
            pend_rw     <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= '0;
            wait_cnt    <= '0;
            cpu_overrun <= 1'b0;
            vga_valid   <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_rd_q    <= 1'b0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (accept) begin
                cpu_busy   <= 1'b1;
                pend_rw    <= cpu_rw;
                pend_addr  <= cpu_addr;
                pend_wdata <= cpu_wdata;
            end else if (issue_cpu) begin
                cpu_busy <= 1'b0;
            end

            if (cpu_stb && cpu_busy) begin
                cpu_overrun <= 1'b1;
            end

            if (issue_cpu) begin
                wait_cnt <= '0;
            end else if (issue_vga && cpu_busy && (wait_cnt != WAIT_LIMIT)) begin
                wait_cnt <= WCW'(wait_cnt + WCW'(1));
            end

            vga_valid <= issue_vga;
            cpu_done  <= issue_cpu;
            cpu_rd_q  <= issue_cpu && pend_rw;

            if (vga_valid) begin
                vga_rdata_q <= mem_rdata;
            end
            if (cpu_rd_q) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data arrives from the RAM in the completion cycle; hold it afterwards.
    assign vga_rdata = vga_valid ? mem_rdata : vga_rdata_q;
    assign cpu_rdata = cpu_rd_q  ? mem_rdata : cpu_rdata_q;

endmodule
